// File: rtl/mem_copy_master.sv
// mem_copy_master: word-granular memory copy engine, initiator side
// of the simulation memory/device request-response bus.
//
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready   copy command handshake
//   cmd_src, cmd_dst      byte addresses, low two bits ignored
//   cmd_len               number of 32-bit words to copy
//   busy                  command in progress
//   done                  one-cycle pulse on completion
//   words_done            words fully written for current/last command
//   out_req_*             bus request channel (valid/ready)
//   out_resp_*            bus response channel (valid/ready)
//
// One transaction is outstanding at a time: each word is a load
// followed by a store, each waiting for its response.

`timescale 1ns/1ps

module mem_copy_master #(
    parameter int LEN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_done,
    output logic             out_req_valid,
    input  logic             out_req_ready,
    output logic             out_req_bits_is_cached,
    output logic             out_req_bits_is_aligned,
    output logic [31:0]      out_req_bits_addr,
    output logic [31:0]      out_req_bits_data,
    output logic             out_req_bits_func,
    output logic [3:0]       out_req_bits_wstrb,
    output logic             out_resp_ready,
    input  logic             out_resp_valid,
    input  logic [31:0]      out_resp_bits_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        WR_REQ,
        WR_RESP,
        FIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      data_q;
    logic [LEN_W-1:0] remain_q;
    logic [LEN_W-1:0] wdone_q;

    logic cmd_fire;
    logic req_fire;
    logic resp_fire;
    logic last_word;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign req_fire  = out_req_valid & out_req_ready;
    assign resp_fire = out_resp_valid & out_resp_ready;
    assign last_word = (remain_q == LEN_W'(1));

    assign out_req_bits_is_cached  = 1'b0;
    assign out_req_bits_is_aligned = 1'b1;
    assign words_done              = wdone_q;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Next state and bus/handshake outputs.
    // Request fields come only from registers that are frozen while
    // a request is pending, so they hold stable under backpressure.
    // ---------------------------------------------------------------
    always_comb begin
        state_d            = state_q;
        cmd_ready          = 1'b0;
        busy               = 1'b1;
        done               = 1'b0;
        out_req_valid      = 1'b0;
        out_req_bits_addr  = 32'h0;
        out_req_bits_data  = 32'h0;
        out_req_bits_func  = 1'b0;
        out_req_bits_wstrb = 4'h0;
        out_resp_ready     = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                // Stale responses (e.g. after an abort) are accepted
                // and dropped here.
                out_resp_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                out_req_valid     = 1'b1;
                out_req_bits_addr = src_q;
                if (out_req_ready) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                out_resp_ready = 1'b1;
                if (out_resp_valid) begin
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                out_req_valid      = 1'b1;
                out_req_bits_addr  = dst_q;
                out_req_bits_data  = data_q;
                out_req_bits_func  = 1'b1;
                out_req_bits_wstrb = 4'hF;
                if (out_req_ready) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                out_resp_ready = 1'b1;
                if (out_resp_valid) begin
                    if (last_word) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Address, count and data registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_q    <= 32'h0;
            dst_q    <= 32'h0;
            data_q   <= 32'h0;
            remain_q <= '0;
            wdone_q  <= '0;
        end else begin
            if (cmd_fire) begin
                src_q    <= {cmd_src[31:2], 2'b00};
                dst_q    <= {cmd_dst[31:2], 2'b00};
                remain_q <= cmd_len;
                wdone_q  <= '0;
            end
            if (state_q == RD_RESP && resp_fire) begin
                data_q <= out_resp_bits_data;
            end
            // Pointers wrap modulo 2^32 by plain 32-bit addition.
            if (state_q == WR_RESP && resp_fire) begin
                src_q    <= src_q + 32'd4;
                dst_q    <= dst_q + 32'd4;
                remain_q <= remain_q - LEN_W'(1);
                wdone_q  <= wdone_q + LEN_W'(1);
            end
        end
    end

    logic unused_req_fire;
    assign unused_req_fire = req_fire;

endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Word-granular memory copy engine; the initiator side of the simulation memory/device request-response bus.
- Accepts one copy command (source, destination, word count) and performs load-then-store pairs with one outstanding transaction at a time.
- Sits between test/control logic and the SimDev-style responder.
- Used to exercise the device model and to preload memory in emulation.

Parameters:
LEN_W, 16, width of the word-count field and of the progress counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  copy command offered
cmd_ready  out  1  engine can accept a command
cmd_src  in  32  source byte address (bits [1:0] ignored)
cmd_dst  in  32  destination byte address (bits [1:0] ignored)
cmd_len  in  LEN_W  number of 32-bit words to copy
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
words_done  out  LEN_W  words fully written for the current/last command
out_req_valid  out  1  bus request valid
out_req_ready  in  1  responder accepts request
out_req_bits_is_cached  out  1  constant 0
out_req_bits_is_aligned  out  1  constant 1
out_req_bits_addr  out  32  word-aligned request address
out_req_bits_data  out  32  store data; 0 on loads
out_req_bits_func  out  1  0 = load, 1 = store
out_req_bits_wstrb  out  4  4'hF on store, 4'h0 on load
out_resp_ready  out  1  engine accepts response
out_resp_valid  in  1  response valid
out_resp_bits_data  in  32  load data (ignored for stores)

Behaviour:
- Reset (asynchronous, active-low): state IDLE, out_req_valid=0, busy=0, done=0, words_done=0, internal address/count/data registers=0. Reset mid-transfer aborts immediately; no completion pulse.
- States: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP, FIN.
- IDLE:
  - cmd_ready=1, out_resp_ready=1 (drains stale responses, e.g. after an abort; they are discarded).
  - On cmd fire: latch src/dst with [1:0] forced to 0, latch len, clear words_done.
  - Next state RD_REQ, or FIN if len==0. FIN with len==0 issues no bus traffic.
- RD_REQ:
  - out_req_valid=1, func=0, wstrb=0, addr=src_ptr.
  - On req fire -> RD_RESP.
- RD_RESP:
  - out_resp_ready=1.
  - On resp fire: capture out_resp_bits_data into data register -> WR_REQ.
- WR_REQ:
  - out_req_valid=1, func=1, wstrb=4'hF, addr=dst_ptr, data=captured word.
  - On req fire -> WR_RESP.
- WR_RESP:
  - out_resp_ready=1.
  - On resp fire: src_ptr+=4, dst_ptr+=4 (mod 2^32, wrap silently), words_done+=1, remaining-=1.
  - Next state RD_REQ if remaining!=0, else FIN.
- FIN: done=1 for exactly this cycle; next state IDLE.
- out_resp_ready=0 in RD_REQ and WR_REQ. cmd_ready=0 in every state except IDLE. busy=1 in every state except IDLE.
- Request hold rule: once out_req_valid is asserted, valid, addr, data, func and wstrb stay stable until out_req_ready is sampled high. Valid is never withdrawn without a fire except by reset.
- Request and response never both fire in the same state. A response in a *_REQ state is a protocol error and is left unacknowledged.
- Latency with a responder giving req_ready=1 and a response in the cycle after the request fire:
  - 4 cycles per word: REQ, RESP, REQ, RESP.
  - done asserts 1 + 4*len cycles after the cmd fire edge.
- words_done holds its final value after FIN until the next command is accepted.

Test Plan:
- Single word: memory[0x100]=0xDEADBEEF, cmd src=0x100 dst=0x200 len=1 -> exactly one load @0x100 then one store @0x200 with data 0xDEADBEEF and wstrb 4'hF; done pulses once, 5 cycles after the cmd fire; words_done=1.
- Burst with unaligned inputs: src=0x1003, dst=0x2002, len=4 -> load addresses 0x1000, 0x1004, 0x1008, 0x100C and store addresses 0x2000, 0x2004, 0x2008, 0x200C; destination contents match source; words_done=4.
- Zero length: cmd len=0 -> no out_req_valid, done 1 cycle after fire, words_done=0.
- Backpressure: responder holds req_ready low for 3 cycles on each request -> request fields remain stable while stalled; data still correct; cmd_ready stays 0 until after done.
- Address wrap: src=0xFFFFFFFC, len=2 -> second load at 0x00000000.
- Abort: assert reset during RD_RESP with the response pending, release, then issue a new command -> stale response is drained in IDLE and discarded, no done pulse for the aborted command, new copy completes correctly.
